// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned PC_STEP   = 2;
    localparam int unsigned MAX_WORDS = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_e;

    // Byte address of instruction word k, matching PC+2 sequencing from 0.
    function automatic logic [15:0] word_addr(input logic [15:0] k);
        return 16'(k * 16'(PC_STEP));
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host byte stream, instruction-memory write port and CPU control signals.
interface imem_boot_loader_if
    import imem_boot_loader_pkg::*;
    ;

    logic               start;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               cpu_halt;
    logic               imem_we;
    logic [15:0]        imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_rst;
    logic               busy;
    logic               done;
    logic               err;
    logic               halted;

    modport master (
        output start, in_valid, in_data, cpu_halt,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_rst, busy, done, err, halted
    );

    modport slave (
        input  start, in_valid, in_data, cpu_halt,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output cpu_rst, busy, done, err, halted
    );

endinterface

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory,
// then releases the CPU from reset and reports its halt back to the host.
module imem_boot_loader #(
    parameter int unsigned MAX_WORDS = imem_boot_loader_pkg::MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    imem_boot_loader_if.slave host
);
    import imem_boot_loader_pkg::*;

    state_e             state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         csum_q, csum_d;
    logic [7:0]         hi_q, hi_d;
    logic               in_ready_q, in_ready_d;
    logic               we_q, we_d;
    logic [15:0]        addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               halted_q, halted_d;

    logic               xfer;
    logic [15:0]        len_rx;
    logic               loading_d;

    assign xfer   = host.in_valid & in_ready_q;
    assign len_rx = {len_q[15:8], host.in_data};

    // State and registered outputs; reset restores the idle, core-held state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            hi_q       <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            hi_q       <= hi_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            halted_q   <= halted_d;
        end
    end

    // Next-state, datapath updates and output decode of the next state.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        hi_d     = hi_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        halted_d = halted_q;

        unique case (state_q)
            S_IDLE:  if (host.start) state_d = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = host.in_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_rx;
                    if ((len_rx != '0) && (32'(len_rx) <= MAX_WORDS)) state_d = S_DATA_HI;
                    else                                              state_d = S_ERROR;
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    hi_d    = host.in_data;
                    csum_d  = csum_q ^ host.in_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    csum_d  = csum_q ^ host.in_data;
                    we_d    = 1'b1;
                    addr_d  = word_addr(cnt_q);
                    wdata_d = {hi_q, host.in_data};
                    cnt_d   = cnt_q + 16'd1;
                    state_d = (cnt_q == len_q - 16'd1) ? S_CHECK : S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (xfer) state_d = (host.in_data == csum_q) ? S_RUN : S_ERROR;
            end
            S_RUN: begin
                // A reload takes priority over a halt reported in the same cycle.
                if (host.start)         state_d  = S_LEN_HI;
                else if (host.cpu_halt) halted_d = 1'b1;
            end
            S_ERROR: if (host.start) state_d = S_LEN_HI;
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_LEN_HI) && (state_q != S_LEN_HI)) begin
            csum_d   = '0;
            cnt_d    = '0;
            halted_d = 1'b0;
        end

        loading_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                     (state_d == S_CHECK);
        in_ready_d = loading_d;
        busy_d     = loading_d;
        cpu_rst_d  = (state_d != S_RUN);
        done_d     = (state_d == S_RUN);
        err_d      = (state_d == S_ERROR);
    end

    assign host.in_ready   = in_ready_q;
    assign host.imem_we    = we_q;
    assign host.imem_addr  = addr_q;
    assign host.imem_wdata = wdata_q;
    assign host.cpu_rst    = cpu_rst_q;
    assign host.busy       = busy_q;
    assign host.done       = done_q;
    assign host.err        = err_q;
    assign host.halted     = halted_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as the
// image is streamed and popped when the DUT pulses imem_we.
module tb_imem_boot_loader;

    logic clk;
    logic rst;

    imem_boot_loader_if bus ();

    imem_boot_loader #(.MAX_WORDS(256)) dut (
        .clk  (clk),
        .rst  (rst),
        .host (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic [15:0] img [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%h data=%h, required no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({bus.imem_addr, bus.imem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                             bus.imem_addr, bus.imem_wdata, e[31:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Offers one byte; returns at the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready=%b, required 1 within 50 cycles", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic gap(input bit toggle, input bit with_start);
        if (toggle) begin
            bus.in_valid = 1'b0;
            bus.start    = with_start;
            @(negedge clk);
            bus.start    = 1'b0;
        end
    endtask

    task automatic load_image(input logic [15:0] n, input bit bad, input bit toggle);
        logic [7:0] cs;
        cs = 8'h00;
        send_byte(n[15:8]); gap(toggle, 1'b0);
        send_byte(n[7:0]);  gap(toggle, 1'b0);
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({16'(2 * i), img[i]});
            cs = cs ^ img[i][15:8] ^ img[i][7:0];
            send_byte(img[i][15:8]); gap(toggle, i == 1);
            send_byte(img[i][7:0]);  gap(toggle, 1'b0);
        end
        send_byte(cs ^ {7'b0, bad});
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.imem_we, bus.cpu_rst, bus.busy, bus.done, bus.err, bus.halted} !== 7'b0010000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy,we,crst,busy,done,err,halt=%b, required 0010000",
                     {bus.in_ready, bus.imem_we, bus.cpu_rst, bus.busy, bus.done, bus.err, bus.halted});
        end
        n_cmp++;
        if ({bus.imem_addr, bus.imem_wdata} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%h data=%h, required 0000 0000", bus.imem_addr, bus.imem_wdata);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start_ignored: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        pulse_start();
        n_cmp++;
        if ({bus.busy, bus.in_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL basic_busy: got busy,ready=%b, required 11", {bus.busy, bus.in_ready});
        end
        img[0] = 16'h1023;
        img[1] = 16'h2045;
        load_image(16'd2, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.cpu_rst, bus.done, bus.busy, bus.in_ready, bus.imem_we, bus.err} !== 6'b010000) begin
            n_fail++;
            $display("FAIL basic_run: got crst,done,busy,rdy,we,err=%b, required 010000",
                     {bus.cpu_rst, bus.done, bus.busy, bus.in_ready, bus.imem_we, bus.err});
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_writes: %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_bad_csum();
        pulse_start();
        n_cmp++;
        if ({bus.cpu_rst, bus.done} !== 2'b10) begin
            n_fail++;
            $display("FAIL reload_rst: got crst,done=%b, required 10", {bus.cpu_rst, bus.done});
        end
        load_image(16'd2, 1'b1, 1'b0);
        n_cmp++;
        if ({bus.err, bus.cpu_rst, bus.done, bus.busy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL csum_err: got err,crst,done,busy=%b, required 1100",
                     {bus.err, bus.cpu_rst, bus.done, bus.busy});
        end
        bus.cpu_halt = 1'b1;
        @(negedge clk);
        bus.cpu_halt = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.err, bus.halted} !== 2'b10) begin
            n_fail++;
            $display("FAIL err_sticky_halt_ignored: got err,halted=%b, required 10", {bus.err, bus.halted});
        end
        pulse_start();
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b, required 0", bus.err);
        end
        img[0] = 16'hBEEF;
        load_image(16'd1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.done, bus.cpu_rst} !== 2'b10) begin
            n_fail++;
            $display("FAIL csum_recover: got done,crst=%b, required 10", {bus.done, bus.cpu_rst});
        end
    endtask

    task automatic test_bad_len();
        logic [15:0] lens [2];
        lens[0] = 16'h0000;
        lens[1] = 16'h0101;
        for (int i = 0; i < 2; i++) begin
            pulse_start();
            send_byte(lens[i][15:8]);
            send_byte(lens[i][7:0]);
            bus.in_valid = 1'b0;
            n_cmp++;
            if ({bus.err, bus.busy, bus.cpu_rst} !== 3'b101) begin
                n_fail++;
                $display("FAIL len_err[%0d]: got err,busy,crst=%b, required 101",
                         i, {bus.err, bus.busy, bus.cpu_rst});
            end
        end
        pulse_start();
        img[0] = 16'h0001; img[1] = 16'h0203; img[2] = 16'h0405;
        img[3] = 16'h0607; img[4] = 16'h0809; img[5] = 16'h0A0B;
        img[6] = 16'h0C0D; img[7] = 16'h0E0F;
        load_image(16'd8, 1'b0, 1'b0);
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL len_max8: done=%b, required 1", bus.done);
        end
    endtask

    task automatic test_toggle();
        pulse_start();
        img[0] = 16'hA1B2; img[1] = 16'hC3D4; img[2] = 16'hE5F6; img[3] = 16'h0718;
        load_image(16'd4, 1'b0, 1'b1);
        n_cmp++;
        if ({bus.done, bus.err, bus.cpu_rst} !== 3'b100) begin
            n_fail++;
            $display("FAIL toggle_run: got done,err,crst=%b, required 100", {bus.done, bus.err, bus.cpu_rst});
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL toggle_writes: %0d writes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_halt();
        bus.cpu_halt = 1'b1;
        @(negedge clk);
        bus.cpu_halt = 1'b0;
        n_cmp++;
        if (bus.halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_set: halted=%b, required 1", bus.halted);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_sticky: halted=%b, required 1", bus.halted);
        end
        pulse_start();
        n_cmp++;
        if ({bus.cpu_rst, bus.halted, bus.done} !== 3'b100) begin
            n_fail++;
            $display("FAIL halt_reload: got crst,halted,done=%b, required 100",
                     {bus.cpu_rst, bus.halted, bus.done});
        end
        img[0] = 16'h5A5A;
        load_image(16'd1, 1'b0, 1'b0);
        bus.cpu_halt = 1'b1;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.cpu_halt = 1'b0;
        bus.start    = 1'b0;
        n_cmp++;
        if ({bus.halted, bus.cpu_rst, bus.busy} !== 3'b011) begin
            n_fail++;
            $display("FAIL halt_vs_start: got halted,crst,busy=%b, required 011",
                     {bus.halted, bus.cpu_rst, bus.busy});
        end
        img[0] = 16'h1234;
        load_image(16'd1, 1'b0, 1'b0);
    endtask

    task automatic test_rst_midload();
        pulse_start();
        img[0] = 16'h1111; img[1] = 16'h2222; img[2] = 16'h3333;
        send_byte(8'h00);
        send_byte(8'h08);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({16'(2 * i), img[i]});
            send_byte(img[i][15:8]);
            send_byte(img[i][7:0]);
        end
        bus.in_data = 8'h44;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus.in_ready, bus.imem_we, bus.cpu_rst, bus.busy, bus.done, bus.err, bus.halted,
             bus.imem_addr, bus.imem_wdata} !== {7'b0010000, 32'h0}) begin
            n_fail++;
            $display("FAIL midload_rst: got flags=%b addr=%h data=%h, required 0010000 0000 0000",
                     {bus.in_ready, bus.imem_we, bus.cpu_rst, bus.busy, bus.done, bus.err, bus.halted},
                     bus.imem_addr, bus.imem_wdata);
        end
        repeat (6) @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++;
        if ({bus.in_ready, bus.busy} !== 2'b00 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midload_idle: got rdy,busy=%b outstanding=%0d, required 00 and 0",
                     {bus.in_ready, bus.busy}, exp_q.size());
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.cpu_halt = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_bad_csum();
        test_bad_len();
        test_toggle();
        test_halt();
        test_rst_midload();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
